// File: rtl/gpu_pkg.sv
// gpu_pkg: shared register offsets, command codes, response codes and the
// rectangle-walker state type for the gpu_fill_engine block.
package gpu_pkg;

  // Word index (byte offset >> 2) of each register
  localparam logic [3:0] REG_ID       = 4'h0;  // 0x00
  localparam logic [3:0] REG_STATUS   = 4'h1;  // 0x04
  localparam logic [3:0] REG_IRQ_EN   = 4'h2;  // 0x08
  localparam logic [3:0] REG_CMD      = 4'h3;  // 0x0C
  localparam logic [3:0] REG_P0       = 4'h4;  // 0x10
  localparam logic [3:0] REG_P1       = 4'h5;  // 0x14
  localparam logic [3:0] REG_COLOR    = 4'h8;  // 0x20
  localparam logic [3:0] REG_PIXCOUNT = 4'h9;  // 0x24

  localparam logic [31:0] CMD_CLEAR     = 32'd1;
  localparam logic [31:0] CMD_FILL_RECT = 32'd2;

  localparam logic [31:0] DEFAULT_ID = 32'hABCD2001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

endpackage

// File: rtl/gpu_rect_walker.sv
// gpu_rect_walker: engine FSM, rectangle clipping, x/y counters, row-base
// accumulator and the framebuffer pixel-write handshake.
module gpu_rect_walker
  import gpu_pkg::*;
#(
  parameter int FB_W  = 320,
  parameter int FB_H  = 240,
  parameter int PIX_W = 16,
  parameter int FB_AW = $clog2(FB_W * FB_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      x0,
  input  logic [15:0]      y0,
  input  logic [15:0]      x1,
  input  logic [15:0]      y1,
  input  logic [PIX_W-1:0] color,
  output logic             busy,
  output logic             done,
  output logic [31:0]      pix_count,
  output logic [FB_AW-1:0] fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic             fb_valid,
  input  logic             fb_ready
);

  localparam logic [15:0]      X_MAX    = 16'(FB_W - 1);
  localparam logic [15:0]      Y_MAX    = 16'(FB_H - 1);
  localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(FB_W);

  state_t           state, state_next;
  logic [15:0]      x0_q, y0_q, x1_q, y1_q;
  logic [15:0]      x_cnt, y_cnt, x_end, y_end;
  logic [15:0]      x1_clip, y1_clip;
  logic [FB_AW-1:0] row_base, first_base;
  logic             empty, px_hs, last_col, last_px;

  assign x1_clip = (x1_q > X_MAX) ? X_MAX : x1_q;
  assign y1_clip = (y1_q > Y_MAX) ? Y_MAX : y1_q;
  assign empty   = (x0_q > x1_clip) || (y0_q > y1_clip) ||
                   (x0_q > X_MAX)   || (y0_q > Y_MAX);
  // Start row only: a constant-coefficient product folded to shifts/adds;
  // every later row is reached by adding FB_W.
  assign first_base = FB_AW'(32'(y0_q) * FB_W);

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign px_hs    = fb_valid && fb_ready;
  assign last_col = (x_cnt == x_end);
  assign last_px  = last_col && (y_cnt == y_end);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = empty ? DONE : RUN;
      RUN:     if (px_hs && last_px) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot, clipping, pixel walk and handshake datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      x_end     <= '0;
      y_end     <= '0;
      row_base  <= '0;
      pix_count <= '0;
      fb_addr   <= '0;
      fb_data   <= '0;
      fb_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state, so every
      // flop here samples the values from before the clock edge.
      case (state)
        IDLE: if (start) begin
          x0_q      <= x0;
          y0_q      <= y0;
          x1_q      <= x1;
          y1_q      <= y1;
          fb_data   <= color;
          pix_count <= '0;
        end
        SETUP: if (!empty) begin
          x_cnt    <= x0_q;
          y_cnt    <= y0_q;
          x_end    <= x1_clip;
          y_end    <= y1_clip;
          row_base <= first_base;
          fb_addr  <= first_base + FB_AW'(x0_q);
          fb_valid <= 1'b1;
        end
        RUN: if (px_hs) begin
          pix_count <= pix_count + 32'd1;
          if (!last_col) begin
            x_cnt   <= x_cnt + 16'd1;
            fb_addr <= fb_addr + FB_AW'(1);
          end else if (last_px) begin
            fb_valid <= 1'b0;
          end else begin
            y_cnt    <= y_cnt + 16'd1;
            x_cnt    <= x0_q;
            row_base <= row_base + ROW_STEP;
            fb_addr  <= row_base + ROW_STEP + FB_AW'(x0_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gpu_fill_engine.sv
// gpu_fill_engine: AXI4-Lite register slave and register file in front of
// the rectangle walker. Optional interrupt support: GPU_FILL_IRQ_EN.
module gpu_fill_engine
  import gpu_pkg::*;
#(
  parameter int          FB_W     = 320,
  parameter int          FB_H     = 240,
  parameter int          PIX_W    = 16,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID,
  parameter int          FB_AW    = $clog2(FB_W * FB_H)
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic [31:0]      S_AXI_AWADDR,
  input  logic             S_AXI_AWVALID,
  output logic             S_AXI_AWREADY,
  input  logic [31:0]      S_AXI_WDATA,
  input  logic [3:0]       S_AXI_WSTRB,
  input  logic             S_AXI_WVALID,
  output logic             S_AXI_WREADY,
  output logic [1:0]       S_AXI_BRESP,
  output logic             S_AXI_BVALID,
  input  logic             S_AXI_BREADY,
  input  logic [31:0]      S_AXI_ARADDR,
  input  logic             S_AXI_ARVALID,
  output logic             S_AXI_ARREADY,
  output logic [31:0]      S_AXI_RDATA,
  output logic [1:0]       S_AXI_RRESP,
  output logic             S_AXI_RVALID,
  input  logic             S_AXI_RREADY,
  output logic [FB_AW-1:0] fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic             fb_valid,
  input  logic             fb_ready,
  output logic             irq
);

  logic             clk, rst_n;
  logic             wr_en, rd_en, wr_map, rd_map, reg_wr;
  logic [3:0]       wr_idx, rd_idx;
  logic [1:0]       wr_resp, rd_resp;
  logic [31:0]      rd_data;
  logic             start, cmd_reject, is_clear;
  logic [15:0]      start_x0, start_y0, start_x1, start_y1;
  logic [31:0]      p0_q, p1_q, pixcount_q;
  logic [PIX_W-1:0] color_q;
  logic             irq_en_q, done_q, cmd_err_q;
  logic             busy, walk_done;
  logic [31:0]      walk_count;
  logic             unused_bits;

  assign clk   = S_AXI_ACLK;
  assign rst_n = S_AXI_ARESETN;

  // Every write is a full word and addresses are word aligned.
  assign unused_bits = ^{S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_en  = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en  = S_AXI_ARREADY && S_AXI_ARVALID;
  assign wr_idx = S_AXI_AWADDR[5:2];
  assign rd_idx = S_AXI_ARADDR[5:2];
  assign wr_map = (S_AXI_AWADDR[31:6] == '0);
  assign rd_map = (S_AXI_ARADDR[31:6] == '0);
  assign reg_wr = wr_en && wr_map;

  // CLEAR covers the whole frame; FILL_RECT uses the programmed corners.
  assign is_clear = (S_AXI_WDATA == CMD_CLEAR);
  assign start_x0 = is_clear ? 16'd0 : p0_q[15:0];
  assign start_y0 = is_clear ? 16'd0 : p0_q[31:16];
  assign start_x1 = is_clear ? 16'(FB_W - 1) : p1_q[15:0];
  assign start_y1 = is_clear ? 16'(FB_H - 1) : p1_q[31:16];

  // Write decode: response code, command launch and busy rejection
  always_comb begin
    wr_resp    = RESP_SLVERR;
    start      = 1'b0;
    cmd_reject = 1'b0;
    if (wr_map) begin
      case (wr_idx)
        REG_IRQ_EN, REG_P0, REG_P1, REG_COLOR: wr_resp = RESP_OKAY;
        REG_CMD: begin
          if (busy) begin
            cmd_reject = wr_en;
          end else begin
            wr_resp = RESP_OKAY;
            start   = wr_en && (is_clear || (S_AXI_WDATA == CMD_FILL_RECT));
          end
        end
        default: ;
      endcase
    end
  end

  // Read decode
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (!rd_map) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (rd_idx)
        REG_ID:       rd_data = ID_VALUE;
        REG_STATUS:   rd_data = {29'b0, cmd_err_q, done_q, busy};
        REG_IRQ_EN:   rd_data = {31'b0, irq_en_q};
        REG_P0:       rd_data = p0_q;
        REG_P1:       rd_data = p1_q;
        REG_COLOR:    rd_data = 32'(color_q);
        REG_PIXCOUNT: rd_data = pixcount_q;
        default:      rd_resp = RESP_SLVERR;
      endcase
    end
  end

  // AXI write channel: one-cycle ready pulse, response held until BREADY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      S_AXI_AWREADY <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
      S_AXI_WREADY  <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
      if (wr_en) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_resp;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // AXI read channel: one-cycle ARREADY pulse, data held until RREADY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
        S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Register file and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q       <= '0;
      p1_q       <= '0;
      color_q    <= '0;
      pixcount_q <= '0;
      done_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      if (reg_wr && wr_idx == REG_P0)    p0_q    <= S_AXI_WDATA;
      if (reg_wr && wr_idx == REG_P1)    p1_q    <= S_AXI_WDATA;
      if (reg_wr && wr_idx == REG_COLOR) color_q <= S_AXI_WDATA[PIX_W-1:0];
      if (walk_done) pixcount_q <= walk_count;
      if (start)          done_q <= 1'b0;
      else if (walk_done) done_q <= 1'b1;
      // A rejection in the same cycle as a STATUS read must not be lost.
      if (cmd_reject)                                   cmd_err_q <= 1'b1;
      else if (rd_en && rd_map && rd_idx == REG_STATUS) cmd_err_q <= 1'b0;
    end
  end

`ifdef GPU_FILL_IRQ_EN
  // Interrupt enable register and registered level interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (reg_wr && wr_idx == REG_IRQ_EN) irq_en_q <= S_AXI_WDATA[0];
      irq <= done_q && irq_en_q;
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  gpu_rect_walker #(
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .PIX_W (PIX_W),
    .FB_AW (FB_AW)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x0        (start_x0),
    .y0        (start_y0),
    .x1        (start_x1),
    .y1        (start_y1),
    .color     (color_q),
    .busy      (busy),
    .done      (walk_done),
    .pix_count (walk_count),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_valid  (fb_valid),
    .fb_ready  (fb_ready)
  );

endmodule

// File: doc/gpu_fill_engine.md
# gpu_fill_engine

- AXI4-Lite register slave plus rectangle-fill engine; the next-generation GPU 2D block.
- Replaces the fixed clear-only GPU with a parametrised framebuffer geometry and pixel width.
- Adds a FILL_RECT command with clipping, busy/error reporting and a completion interrupt.
- Sits between the CPU AXI-Lite interconnect and the framebuffer memory write port.

## Interface
Parameters:
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- PIX_W, 16, pixel width in bits (1..32)
- ID_VALUE, 32'hABCD2001, value of ID register
- FB_AW, $clog2(FB_W*FB_H), derived pixel address width (not to be overridden)

Ports. One clock; reset is asynchronous, active-low.
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AW{ADDR[31:0],VALID}/AWREADY, S_AXI_W{DATA[31:0],STRB[3:0],VALID}/WREADY, S_AXI_B{RESP[1:0],VALID}/BREADY: AXI4-Lite write channels
- S_AXI_AR{ADDR[31:0],VALID}/ARREADY, S_AXI_R{DATA[31:0],RESP[1:0],VALID}/RREADY: AXI4-Lite read channels
- fb_addr  out  FB_AW  pixel address, y*FB_W + x
- fb_data  out  PIX_W  pixel value
- fb_valid  out  1  pixel write request
- fb_ready  in  1  framebuffer accepts pixel
- irq  out  1  level interrupt

## Operation
Register map (byte offsets; addr[5:2] decoded):
- 0x00 ID (RO) = ID_VALUE
- 0x04 STATUS (RO):
  - bit0 busy
  - bit1 done (sticky; cleared by next accepted CMD)
  - bit2 cmd_err (sticky; cleared by any STATUS read)
- 0x08 IRQ_EN (RW, bit0)
- 0x0C CMD (WO):
  - 1 = CLEAR (full frame)
  - 2 = FILL_RECT
  - other values ignored, OKAY response
- 0x10 P0 (RW): x0 in [15:0], y0 in [31:16]
- 0x14 P1 (RW): x1, y1, inclusive corner
- 0x20 COLOR (RW): [PIX_W-1:0]
- 0x24 PIXCOUNT (RO): pixels written by the last operation, 32-bit

Reads from the WO or unmapped offsets return 0 with SLVERR. Writes to RO or unmapped offsets are dropped and respond SLVERR. WSTRB is ignored; every write is a full word.

CMD handling:
- CMD write while busy is rejected: BRESP=SLVERR, cmd_err set, engine unaffected.
- An accepted CMD snapshots COLOR, P0 and P1. Later register writes do not affect the running operation.

Engine FSM:
- IDLE → SETUP on an accepted CMD.
- SETUP (1 cycle) → RUN.
  - Clip: x1 = min(x1, FB_W-1), y1 = min(y1, FB_H-1).
  - If x0 > x1, y0 > y1, x0 ≥ FB_W or y0 ≥ FB_H, the operation is empty and goes straight to DONE.
  - CLEAR uses (0,0)–(FB_W-1, FB_H-1).
- RUN → DONE once the last pixel handshake completes.
  - Walk row-major. fb_valid is held with stable addr/data until fb_ready.
  - Row base is accumulated by adding FB_W; no multiplier.
- DONE (1 cycle) → IDLE. Sets done and latches PIXCOUNT.
- busy = (state != IDLE), so a CMD arriving during DONE is rejected.

## Timing
Reset values: all S_AXI ready/valid outputs 0, RESP 0, RDATA 0, fb_valid 0, fb_addr 0, fb_data 0, irq 0, all registers 0, FSM in IDLE. Reset asserted mid-operation deasserts fb_valid immediately (asynchronously) and abandons the operation.

Write channel:
- AWREADY and WREADY are asserted together for one cycle only when AWVALID, WVALID and !BVALID are all true.
- BVALID rises the next cycle and holds until BREADY.

Read channel:
- ARREADY pulses when ARVALID && !RVALID.
- RVALID and RDATA follow the next cycle and hold until RREADY.

CMD latency:
- CMD handshake at edge N → busy visible on a STATUS read issued after N.
- SETUP at N+1; first fb_valid at N+2.
- With fb_ready stuck at 1: one pixel per cycle, so DONE occurs k cycles after the first fb_valid for k pixels.
- An empty operation reaches DONE at N+2.

## Configuration
- GPU_FILL_IRQ_EN defined:
  - irq = done & IRQ_EN[0], registered.
  - IRQ_EN is read/write.
- Undefined:
  - irq tied 0.
  - IRQ_EN reads 0; writes to it respond OKAY and are ignored.

## Structure
- Package gpu_pkg holds:
  - register offsets, command codes, default ID
  - state enum (IDLE, SETUP, RUN, DONE)
  - RESP_OKAY/RESP_SLVERR constants
- Sub-module gpu_rect_walker contains the FSM, clipping, x/y counters, row-base accumulator and the fb_* handshake.
- The top level holds the AXI-Lite slave and the register file.

## Test plan
- After reset, read 0x00 → RDATA = 0xABCD2001, RRESP = OKAY. Read 0x40 → 0 with SLVERR.
- FB_W=8, FB_H=4, COLOR=0xF800, CMD=1, fb_ready=1 → 32 writes at addresses 0..31 with data 0xF800 on consecutive cycles. PIXCOUNT=32, done=1.
- P0=(2,1), P1=(20,2), CMD=2 with an 8×4 framebuffer → clipped to x 2..7 on rows 1–2: addresses 10..15 and 18..23, PIXCOUNT=12.
- Toggle fb_ready 1-0-1 during a fill → addr/data stable while stalled, no pixel lost or duplicated.
- CMD write while busy → BRESP=SLVERR and STATUS bit2=1; the running fill completes unchanged. A second STATUS read returns bit2=0.
- With GPU_FILL_IRQ_EN defined and IRQ_EN=1, run P0=(5,0), P1=(1,0) → empty op, irq rises, PIXCOUNT=0. Assert reset mid-fill → fb_valid and irq drop immediately.
